// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder controller: drives one external 4-bit adder slice for NIBBLES cycles, LSB nibble first.
// Define NSAC_SUB_EN to add a 'sub' port that turns the operation into A-B.
module nibble_serial_add_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4*NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic [3:0]   slc_a,
  output logic [3:0]   slc_b,
  output logic         slc_cin,
  input  logic [3:0]   slc_sum,
  input  logic         slc_cout
`ifdef NSAC_SUB_EN
  ,
  input  logic         sub
`endif
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] idx;
  logic          carry_q;
  logic          sub_q;
  logic          sub_in;
  logic          last;
  logic          accept;

`ifdef NSAC_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign last   = (idx == LAST_IDX);
  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (res_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Slice inputs are forced quiet outside RUN so the shared adder sees no toggling.
  always_comb begin
    cmd_ready = (state == IDLE);
    res_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
    slc_a     = '0;
    slc_b     = '0;
    slc_cin   = 1'b0;
    if (state == RUN) begin
      slc_a   = a_q[4*idx +: 4];
      slc_b   = b_q[4*idx +: 4] ^ {4{sub_q}};
      slc_cin = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      idx     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q     <= a;
          b_q     <= b;
          sub_q   <= sub_in;
          carry_q <= cin | sub_in;
          idx     <= '0;
        end
        RUN: begin
          sum[4*idx +: 4] <= slc_sum;
          carry_q         <= slc_cout;
          idx             <= last ? '0 : idx + 1'b1;
          if (last) cout  <= slc_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4) with a behavioural 4-bit slice attached.
module tb_nibble_serial_add_ctrl;
  localparam int N = 4;
  localparam int W = 4*N;

  logic         clk = 1'b0;
  logic         rst_n, cmd_valid, cmd_ready, cin, res_valid, res_ready, cout, busy;
  logic [W-1:0] a, b, sum;
  logic [3:0]   slc_a, slc_b, slc_sum;
  logic         slc_cin, slc_cout;
  logic         sub_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // external adder slice
  assign {slc_cout, slc_sum} = {1'b0, slc_a} + {1'b0, slc_b} + {4'b0, slc_cin};

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .a(a), .b(b), .cin(cin), .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .cout(cout), .busy(busy), .slc_a(slc_a), .slc_b(slc_b),
    .slc_cin(slc_cin), .slc_sum(slc_sum), .slc_cout(slc_cout)
`ifdef NSAC_SUB_EN
    , .sub(sub_s)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    check({tag, ".sum"},       32'(sum),       32'd0);
    check({tag, ".cout"},      32'(cout),      32'd0);
    check({tag, ".slc"},       {23'd0, slc_a, slc_b, slc_cin}, 32'd0);
  endtask

  // One full operation: handshake, N RUN cycles, DONE held for 'hold' cycles, back to IDLE.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb, input logic [W-1:0] exp_sum,
                       input logic exp_cout, input int hold, input bit toggle);
    logic [3:0] an, bn;
    logic       c;
    logic [4:0] t;
    check({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
    a = av; b = bv; cin = ci; sub_s = sb; cmd_valid = 1'b1; res_ready = 1'b0;
    tick();
    cmd_valid = toggle;
    c = sb ? 1'b1 : ci;
    for (int i = 0; i < N; i++) begin
      if (toggle) begin
        a = W'($urandom); b = W'($urandom); cin = ~cin;
      end
      an = av[4*i +: 4];
      bn = sb ? ~bv[4*i +: 4] : bv[4*i +: 4];
      check($sformatf("%s.run%0d.ready", tag, i), 32'(cmd_ready), 32'd0);
      check($sformatf("%s.run%0d.valid", tag, i), 32'(res_valid), 32'd0);
      check($sformatf("%s.run%0d.slc", tag, i), {23'd0, slc_a, slc_b, slc_cin}, {23'd0, an, bn, c});
      t = {1'b0, an} + {1'b0, bn} + {4'd0, c};
      c = t[4];
      tick();
    end
    cmd_valid = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      check($sformatf("%s.done%0d.valid", tag, h), 32'(res_valid), 32'd1);
      check($sformatf("%s.done%0d.ready", tag, h), 32'(cmd_ready), 32'd0);
      check($sformatf("%s.done%0d.sum", tag, h),   32'(sum),       32'(exp_sum));
      check($sformatf("%s.done%0d.cout", tag, h),  32'(cout),      32'(exp_cout));
      check($sformatf("%s.done%0d.slc", tag, h),   {23'd0, slc_a, slc_b, slc_cin}, 32'd0);
      if (h == hold) res_ready = 1'b1;
      tick();
    end
    res_ready = 1'b0;
    check({tag, ".back_idle.ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".back_idle.valid"}, 32'(res_valid), 32'd0);
    check({tag, ".back_idle.busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_s = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    do_op("carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 0, 1'b0);
    do_op("wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
    do_op("with_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 0, 1'b0);
    do_op("hold7",       16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 7, 1'b0);

    // reset lands at the edge ending the second RUN cycle
    a = 16'h8888; b = 16'h8888; cin = 1'b0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("mid_reset.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    for (int i = 0; i < N + 3; i++) begin
      tick();
      check($sformatf("mid_reset.quiet%0d.valid", i), 32'(res_valid), 32'd0);
    end
    do_op("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0, 1'b0);

    do_op("toggle_inputs", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 2, 1'b1);

`ifdef NSAC_SUB_EN
    do_op("sub_borrow",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 0, 1'b0);
    do_op("sub_no_borrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
